// File: rtl/bgpu_pkg.sv
// ============================================================
// bgpu_pkg: shared types and helpers for the warp front end
// Rev 1.0
// ============================================================
`default_nettype none

package bgpu_pkg;

   typedef enum logic [1:0] {
      FE_IDLE     = 2'd0,
      FE_READY    = 2'd1,
      FE_WAIT_DEC = 2'd2,
      FE_WAIT_BRU = 2'd3
   } fetch_state_e;

   function automatic int unsigned wrap_inc(input int unsigned val, input int unsigned modulus);
      return (val + 1 >= modulus) ? 0 : val + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/warp_rr_select.sv
// ============================================================
// warp_rr_select: combinational round-robin pick of one requesting warp
// Rev 1.0
// ============================================================
`default_nettype none

module warp_rr_select #(
   parameter int NumWarps = 8,
   parameter int WidWidth = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
   input  logic [NumWarps-1:0] req_i,
   input  logic [WidWidth-1:0] ptr_i,
   output logic                grant_valid_o,
   output logic [WidWidth-1:0] grant_id_o
);

   logic [WidWidth:0]   sum;
   logic [WidWidth-1:0] idx;

   // Scan from the farthest offset down so the nearest request to the pointer wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_id_o    = '0;
      sum           = '0;
      idx           = '0;
      for (int i = NumWarps - 1; i >= 0; i--) begin
         sum = {1'b0, ptr_i} + (WidWidth + 1)'(i);
         if (sum >= (WidWidth + 1)'(NumWarps)) begin
            sum = sum - (WidWidth + 1)'(NumWarps);
         end
         idx = sum[WidWidth-1:0];
         if (req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_id_o    = idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetcher.sv
// ============================================================
// fetcher: per-warp PC keeper and round-robin fetch request issuer
// Rev 1.0
// ============================================================
`default_nettype none

module fetcher
   import bgpu_pkg::*;
#(
   parameter int PcWidth        = 32,
   parameter int NumWarps       = 8,
   parameter int WarpWidth      = 32,
   parameter int SubwarpIdWidth = WarpWidth > 1 ? $clog2(WarpWidth) : 1,
   parameter int WidWidth       = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_valid_i,
   output logic                      start_ready_o,
   input  logic [PcWidth-1:0]        start_pc_i,
   input  logic [WarpWidth-1:0]      start_act_mask_i,
   input  logic                      ic_ready_i,
   output logic                      fe_valid_o,
   output logic [PcWidth-1:0]        fe_pc_o,
   output logic [WarpWidth-1:0]      fe_act_mask_o,
   output logic [WidWidth-1:0]       fe_warp_id_o,
   output logic [SubwarpIdWidth-1:0] fe_subwarp_id_o,
   input  logic                      dec_decoded_i,
   input  logic [WidWidth-1:0]       dec_decoded_warp_id_i,
   input  logic                      dec_stop_warp_i,
   input  logic                      dec_decoded_branch_i,
   input  logic [PcWidth-1:0]        dec_decoded_next_pc_i,
   input  logic                      bru_valid_i,
   input  logic [WidWidth-1:0]       bru_warp_id_i,
   input  logic [PcWidth-1:0]        bru_next_pc_i,
   output logic                      warp_stopped_o,
   output logic [WidWidth-1:0]       warp_stopped_id_o,
   output logic                      all_idle_o
);

   fetch_state_e          state [NumWarps];
   logic [PcWidth-1:0]    pc    [NumWarps];
   logic [WarpWidth-1:0]  mask  [NumWarps];
   logic [WidWidth-1:0]   rr_ptr;
   logic                  lock;
   logic [WidWidth-1:0]   lock_id;
   logic                  stopped;
   logic [WidWidth-1:0]   stopped_id;
   logic                  start_pend;

   logic [NumWarps-1:0]   idle_vec;
   logic [NumWarps-1:0]   ready_vec;
   logic [WidWidth-1:0]   start_id;
   logic                  start_fire;
   logic                  rr_valid;
   logic [WidWidth-1:0]   rr_id;
   logic                  sel_valid;
   logic [WidWidth-1:0]   sel_id;
   logic                  fetch_fire;

   always_comb begin
      idle_vec  = '0;
      ready_vec = '0;
      start_id  = '0;
      for (int w = NumWarps - 1; w >= 0; w--) begin
         idle_vec[w]  = (state[w] == FE_IDLE);
         ready_vec[w] = (state[w] == FE_READY);
         if (state[w] == FE_IDLE) begin
            start_id = WidWidth'(w);
         end
      end
   end

   warp_rr_select #(
      .NumWarps (NumWarps),
      .WidWidth (WidWidth)
   ) u_rr (
      .req_i         (ready_vec),
      .ptr_i         (rr_ptr),
      .grant_valid_o (rr_valid),
      .grant_id_o    (rr_id)
   );

   // A stalled request keeps its warp so pc/mask/id cannot change under the cache.
   assign sel_valid  = lock | rr_valid;
   assign sel_id     = lock ? lock_id : rr_id;
   assign fetch_fire = sel_valid & ic_ready_i;
   assign start_fire = start_valid_i & start_ready_o;

   assign start_ready_o     = |idle_vec;
   assign all_idle_o        = &idle_vec;
   assign fe_valid_o        = sel_valid;
   assign fe_pc_o           = sel_valid ? pc[sel_id]   : '0;
   assign fe_act_mask_o     = sel_valid ? mask[sel_id] : '0;
   assign fe_warp_id_o      = sel_valid ? sel_id       : '0;
   assign fe_subwarp_id_o   = '0;
   assign warp_stopped_o    = stopped;
   assign warp_stopped_id_o = stopped_id;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int w = 0; w < NumWarps; w++) begin
            state[w] <= FE_IDLE;
            pc[w]    <= '0;
            mask[w]  <= '0;
         end
         rr_ptr     <= '0;
         lock       <= 1'b0;
         lock_id    <= '0;
         stopped    <= 1'b0;
         stopped_id <= '0;
      end else begin
         for (int w = 0; w < NumWarps; w++) begin
            case (state[w])
               FE_IDLE: begin
                  if (start_fire && start_id == WidWidth'(w)) begin
                     state[w] <= FE_READY;
                     pc[w]    <= start_pc_i;
                     mask[w]  <= start_act_mask_i;
                  end
               end
               FE_READY: begin
                  if (fetch_fire && sel_id == WidWidth'(w)) begin
                     state[w] <= FE_WAIT_DEC;
                  end
               end
               FE_WAIT_DEC: begin
                  if (dec_decoded_i && dec_decoded_warp_id_i == WidWidth'(w)) begin
                     if (dec_stop_warp_i) begin
                        state[w] <= FE_IDLE;
                     end else if (dec_decoded_branch_i) begin
                        state[w] <= FE_WAIT_BRU;
                     end else begin
                        state[w] <= FE_READY;
                        pc[w]    <= dec_decoded_next_pc_i;
                     end
                  end
               end
               FE_WAIT_BRU: begin
                  if (bru_valid_i && bru_warp_id_i == WidWidth'(w)) begin
                     state[w] <= FE_READY;
                     pc[w]    <= bru_next_pc_i;
                  end
               end
               default: state[w] <= FE_IDLE;
            endcase
         end

         stopped <= dec_decoded_i & dec_stop_warp_i;
         if (dec_decoded_i && dec_stop_warp_i) begin
            stopped_id <= dec_decoded_warp_id_i;
         end

         if (fetch_fire) begin
            rr_ptr <= WidWidth'(wrap_inc(32'(sel_id), NumWarps));
            lock   <= 1'b0;
         end else if (sel_valid) begin
            lock    <= 1'b1;
            lock_id <= sel_id;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         start_pend <= 1'b0;
      end else begin
         start_pend <= start_valid_i & ~start_ready_o;
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         a_dec_state: assert (!dec_decoded_i || state[dec_decoded_warp_id_i] == FE_WAIT_DEC);
         a_bru_state: assert (!bru_valid_i || state[bru_warp_id_i] == FE_WAIT_BRU);
         a_start_hold: assert (!start_pend || start_valid_i);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetcher.sv
// ============================================================
// tb_fetcher: directed self-checking bench for fetcher
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] start_pc;
   logic [31:0] start_mask;
   logic        ic_ready;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic [31:0] fe_mask;
   logic [2:0]  fe_id;
   logic [4:0]  fe_sub;
   logic        dec_decoded;
   logic [2:0]  dec_id;
   logic        dec_stop;
   logic        dec_branch;
   logic [31:0] dec_next_pc;
   logic        bru_valid;
   logic [2:0]  bru_id;
   logic [31:0] bru_pc;
   logic        stopped;
   logic [2:0]  stopped_id;
   logic        all_idle;

   int n_cmp = 0;
   int n_mis = 0;

   fetcher dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .start_valid_i         (start_valid),
      .start_ready_o         (start_ready),
      .start_pc_i            (start_pc),
      .start_act_mask_i      (start_mask),
      .ic_ready_i            (ic_ready),
      .fe_valid_o            (fe_valid),
      .fe_pc_o               (fe_pc),
      .fe_act_mask_o         (fe_mask),
      .fe_warp_id_o          (fe_id),
      .fe_subwarp_id_o       (fe_sub),
      .dec_decoded_i         (dec_decoded),
      .dec_decoded_warp_id_i (dec_id),
      .dec_stop_warp_i       (dec_stop),
      .dec_decoded_branch_i  (dec_branch),
      .dec_decoded_next_pc_i (dec_next_pc),
      .bru_valid_i           (bru_valid),
      .bru_warp_id_i         (bru_id),
      .bru_next_pc_i         (bru_pc),
      .warp_stopped_o        (stopped),
      .warp_stopped_id_o     (stopped_id),
      .all_idle_o            (all_idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dec_set(input logic [2:0] id, input logic stop, input logic br, input logic [31:0] npc);
      dec_decoded = 1'b1;
      dec_id      = id;
      dec_stop    = stop;
      dec_branch  = br;
      dec_next_pc = npc;
   endtask

   task automatic dec_clr;
      dec_decoded = 1'b0;
      dec_stop    = 1'b0;
      dec_branch  = 1'b0;
   endtask

   initial begin
      logic [2:0]  prev_id;
      logic [31:0] prev_pc;
      logic [31:0] exp_pc;
      int          g;

      rst = 1'b1;
      start_valid = 1'b0; start_pc = '0; start_mask = '0; ic_ready = 1'b0;
      dec_decoded = 1'b0; dec_id = '0; dec_stop = 1'b0; dec_branch = 1'b0; dec_next_pc = '0;
      bru_valid = 1'b0; bru_id = '0; bru_pc = '0;
      prev_id = '0; prev_pc = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_fe_valid", fe_valid, 0);
      chk("rst_start_ready", start_ready, 1);
      chk("rst_all_idle", all_idle, 1);
      chk("rst_stopped", stopped, 0);
      chk("rst_fe_pc", fe_pc, 0);
      chk("rst_fe_sub", fe_sub, 0);
      rst = 1'b0;
      tick;
      chk("post_rst_fe_valid", fe_valid, 0);

      // single warp launch and sequential refetch
      start_valid = 1'b1; start_pc = 32'h10; start_mask = 32'hFFFF_FFFF; ic_ready = 1'b1;
      tick;
      start_valid = 1'b0;
      chk("t1_valid", fe_valid, 1);
      chk("t1_pc", fe_pc, 32'h10);
      chk("t1_id", fe_id, 0);
      chk("t1_mask", fe_mask, 32'hFFFF_FFFF);
      chk("t1_not_idle", all_idle, 0);
      tick;
      chk("t1_in_flight", fe_valid, 0);
      dec_set(3'd0, 1'b0, 1'b0, 32'h11);
      tick;
      dec_clr;
      chk("t1_refetch_valid", fe_valid, 1);
      chk("t1_refetch_pc", fe_pc, 32'h11);
      tick;
      dec_set(3'd0, 1'b1, 1'b0, 32'h0);
      tick;
      dec_clr;
      chk("t1_stop_pulse", stopped, 1);
      chk("t1_stop_id", stopped_id, 0);
      chk("t1_all_idle", all_idle, 1);
      tick;
      chk("t1_pulse_end", stopped, 0);

      // three warps, stalled cache holds the locked warp
      ic_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_valid = 1'b1;
         start_pc    = 32'h100 * (i + 1);
         start_mask  = 32'h0000_00FF << (8 * i);
         tick;
      end
      start_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t2_hold_id", fe_id, 0);
         chk("t2_hold_pc", fe_pc, 32'h100);
         tick;
      end

      // prompt decode: grant order 0,1,2,0,1,2
      ic_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         g = i % 3;
         exp_pc = 32'h100 * (g + 1) + 32'(i / 3);
         chk("t2_rr_id", fe_id, 3'(g));
         chk("t2_rr_pc", fe_pc, exp_pc);
         if (i > 0) begin
            dec_set(prev_id, 1'b0, 1'b0, prev_pc + 32'h1);
         end
         tick;
         dec_clr;
         prev_id = 3'(g);
         prev_pc = exp_pc;
      end

      // branch on warp2 parks it until resolution
      ic_ready = 1'b0;
      dec_set(3'd2, 1'b0, 1'b1, 32'h302);
      tick;
      dec_clr;
      chk("t3_lock_id", fe_id, 0);
      chk("t3_lock_pc", fe_pc, 32'h102);
      ic_ready = 1'b1;
      tick;
      chk("t3_w1_id", fe_id, 1);
      chk("t3_w1_pc", fe_pc, 32'h202);
      tick;
      chk("t3_none_ready", fe_valid, 0);
      bru_valid = 1'b1; bru_id = 3'd2; bru_pc = 32'h40;
      tick;
      bru_valid = 1'b0;
      chk("t3_bru_valid", fe_valid, 1);
      chk("t3_bru_id", fe_id, 2);
      chk("t3_bru_pc", fe_pc, 32'h40);
      tick;

      // stop and launch in the same cycle
      dec_set(3'd1, 1'b1, 1'b0, 32'h0);
      start_valid = 1'b1; start_pc = 32'h500; start_mask = 32'hF;
      tick;
      dec_clr;
      start_valid = 1'b0;
      chk("t4_stop_pulse", stopped, 1);
      chk("t4_stop_id", stopped_id, 1);
      chk("t4_new_id", fe_id, 3);
      chk("t4_new_pc", fe_pc, 32'h500);
      chk("t4_new_mask", fe_mask, 32'hF);
      tick;
      chk("t4_pulse_end", stopped, 0);
      dec_set(3'd0, 1'b1, 1'b0, 32'h0);
      tick;
      chk("t4_not_all_idle", all_idle, 0);
      dec_set(3'd2, 1'b1, 1'b0, 32'h0);
      tick;
      dec_set(3'd3, 1'b1, 1'b0, 32'h0);
      tick;
      dec_clr;
      chk("t4_all_idle", all_idle, 1);
      chk("t4_last_stop_id", stopped_id, 3);

      // fill all eight warps, ninth launch stalls until a stop
      ic_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         start_valid = 1'b1;
         start_pc    = 32'h600 + 32'(i);
         start_mask  = 32'hFFFF_FFFF;
         tick;
      end
      chk("t5_full", start_ready, 0);
      start_pc = 32'h700;
      tick;
      tick;
      chk("t5_stall", start_ready, 0);
      ic_ready = 1'b1;
      tick;
      ic_ready = 1'b0;
      dec_set(3'd0, 1'b1, 1'b0, 32'h0);
      tick;
      dec_clr;
      chk("t5_freed", start_ready, 1);
      chk("t5_stop_id", stopped_id, 0);
      tick;
      start_valid = 1'b0;
      chk("t5_refull", start_ready, 0);
      chk("t5_fe_id", fe_id, 1);
      chk("t5_fe_pc", fe_pc, 32'h601);

      // asynchronous reset with warps in flight
      ic_ready = 1'b1;
      tick;
      dec_set(3'd1, 1'b0, 1'b1, 32'h0);
      tick;
      dec_clr;
      ic_ready = 1'b0;
      chk("t6_pre_valid", fe_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_fe_valid", fe_valid, 0);
      chk("t6_start_ready", start_ready, 1);
      chk("t6_all_idle", all_idle, 1);
      chk("t6_fe_pc", fe_pc, 0);
      chk("t6_fe_id", fe_id, 0);
      chk("t6_stopped", stopped, 0);
      tick;
      rst = 1'b0;
      tick;
      chk("t6_after_valid", fe_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
